// File: rtl/demorgan_pkg.sv
// Shared types and constants for the De Morgan sweep checker and its golden model.
package demorgan_pkg;

  localparam int unsigned VecW = 2;
  localparam int unsigned ObsW = 8;

  // Bit positions inside the gate block's output bundle
  localparam int unsigned ObsNA      = 0;
  localparam int unsigned ObsNB      = 1;
  localparam int unsigned ObsNAandNB = 2;
  localparam int unsigned ObsAandB   = 3;
  localparam int unsigned ObsNAandB  = 4;
  localparam int unsigned ObsNAorNB  = 5;
  localparam int unsigned ObsAorB    = 6;
  localparam int unsigned ObsNAorB   = 7;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCheck,
    StDone
  } stateE;

endpackage

// File: rtl/demorgan_golden.sv
// Combinational reference: maps {A,B} to the eight expected gate-block outputs.
module demorgan_golden
  import demorgan_pkg::*;
(
  input  logic [VecW-1:0] vec,
  output logic [ObsW-1:0] expected
);

  logic a;
  logic b;

  assign a = vec[1];
  assign b = vec[0];

  always_comb begin
    expected             = '0;
    expected[ObsNA]      = ~a;
    expected[ObsNB]      = ~b;
    expected[ObsNAandNB] = ~a & ~b;
    expected[ObsAandB]   = a & b;
    expected[ObsNAandB]  = ~(a & b);
    expected[ObsNAorNB]  = ~a | ~b;
    expected[ObsAorB]    = a | b;
    expected[ObsNAorB]   = ~(a | b);
  end

endmodule

// File: rtl/demorgan_sweep_checker.sv
// Sweeps {A,B} through all four combinations REPEAT times, checks the gate block's
// outputs against the golden model and reports pass/fail with first-failure capture.
module demorgan_sweep_checker
  import demorgan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned REPEAT        = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             drv_a,
  output logic             drv_b,
  input  logic [ObsW-1:0]  obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_count,
  output logic [VecW-1:0]  first_fail_vec,
  output logic [ObsW-1:0]  first_fail_mask
);

  localparam int unsigned SetW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SweepW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [SetW-1:0]   SetLast   = SetW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [SweepW-1:0] SweepLast = SweepW'(REPEAT - 1);
  localparam logic [CNT_W-1:0]  CntMax    = '1;
  // With no settle time each vector goes straight to its check cycle
  localparam stateE StEnterVec = (SETTLE_CYCLES == 0) ? StCheck : StSettle;

  stateE             stateQ, stateD;
  logic [VecW-1:0]   vecQ, vecD;
  logic [SweepW-1:0] sweepQ, sweepD;
  logic [SetW-1:0]   setCntQ, setCntD;
  logic [CNT_W-1:0]  failCntQ, failCntD;
  logic              passQ, passD;
  logic [VecW-1:0]   firstVecQ, firstVecD;
  logic [ObsW-1:0]   firstMaskQ, firstMaskD;

  logic [ObsW-1:0] expVec;
  logic [ObsW-1:0] diff;
  logic            mismatch;
  logic            lastVec;

  demorgan_golden uGolden (
    .vec      (vecQ),
    .expected (expVec)
  );

  assign diff     = obs ^ expVec;
  assign mismatch = (stateQ == StCheck) && (diff != '0);
  assign lastVec  = (vecQ == 2'd3) && (sweepQ == SweepLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:   if (start) stateD = StEnterVec;
      StSettle: if (setCntQ == SetLast) stateD = StCheck;
      StCheck:  stateD = lastVec ? StDone : StEnterVec;
      StDone:   stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  always_comb begin
    busy = (stateQ == StSettle) || (stateQ == StCheck);
    done = (stateQ == StDone);
  end

  always_comb begin
    vecD       = vecQ;
    sweepD     = sweepQ;
    setCntD    = setCntQ;
    failCntD   = failCntQ;
    passD      = passQ;
    firstVecD  = firstVecQ;
    firstMaskD = firstMaskQ;
    case (stateQ)
      StIdle: begin
        if (start) begin
          vecD       = '0;
          sweepD     = '0;
          setCntD    = '0;
          failCntD   = '0;
          passD      = 1'b0;
          firstVecD  = '0;
          firstMaskD = '0;
        end
      end
      StSettle: setCntD = setCntQ + 1'b1;
      StCheck: begin
        setCntD = '0;
        if (mismatch) begin
          // Count never returns to zero once bumped, so zero means no failure yet
          if (failCntQ == '0) begin
            firstVecD  = vecQ;
            firstMaskD = diff;
          end
          if (failCntQ != CntMax) failCntD = failCntQ + 1'b1;
        end
        if (lastVec) begin
          vecD  = '0;
          passD = (failCntD == '0);
        end else begin
          vecD = vecQ + 1'b1;
          if (vecQ == 2'd3) sweepD = sweepQ + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vecQ       <= '0;
      sweepQ     <= '0;
      setCntQ    <= '0;
      failCntQ   <= '0;
      passQ      <= 1'b0;
      firstVecQ  <= '0;
      firstMaskQ <= '0;
    end else begin
      vecQ       <= vecD;
      sweepQ     <= sweepD;
      setCntQ    <= setCntD;
      failCntQ   <= failCntD;
      passQ      <= passD;
      firstVecQ  <= firstVecD;
      firstMaskQ <= firstMaskD;
    end
  end

  assign drv_a           = vecQ[1];
  assign drv_b           = vecQ[0];
  assign pass            = passQ;
  assign fail_count      = failCntQ;
  assign first_fail_vec  = firstVecQ;
  assign first_fail_mask = firstMaskQ;

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Bench for demorgan_sweep_checker: four instances with different parameters, a faultable
// gate-block model on each, directed run table plus randomized fault masks.
module tb_demorgan_sweep_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start [4];
  logic       drvA [4];
  logic       drvB [4];
  logic       busy [4];
  logic       done [4];
  logic       pass [4];
  logic [7:0] fc [4];
  logic [1:0] fc3;
  logic [1:0] ffv [4];
  logic [7:0] ffm [4];
  logic [7:0] obs [4];
  logic [7:0] clrMask [4];
  logic [7:0] xorMask [4];

  logic [1:0] gVec;
  logic [7:0] gExp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Gate block behaviour from truth rules: a,b as integers 0/1
  function automatic logic [7:0] gateModel(input logic [1:0] v);
    int a;
    int b;
    logic [7:0] r;
    a = int'(v[1]);
    b = int'(v[0]);
    r[0] = (a == 0);
    r[1] = (b == 0);
    r[2] = (a + b == 0);
    r[3] = (a * b == 1);
    r[4] = (a * b == 0);
    r[5] = (a * b == 0);
    r[6] = (a + b > 0);
    r[7] = (a + b == 0);
    return r;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gObs
    assign obs[g] = (gateModel({drvA[g], drvB[g]}) & ~clrMask[g]) ^ xorMask[g];
  end

  assign fc[3] = {6'b0, fc3};

  demorgan_sweep_checker #(.SETTLE_CYCLES(1), .REPEAT(1), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .drv_a(drvA[0]), .drv_b(drvB[0]),
    .obs(obs[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail_count(fc[0]),
    .first_fail_vec(ffv[0]), .first_fail_mask(ffm[0])
  );
  demorgan_sweep_checker #(.SETTLE_CYCLES(1), .REPEAT(3), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .drv_a(drvA[1]), .drv_b(drvB[1]),
    .obs(obs[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail_count(fc[1]),
    .first_fail_vec(ffv[1]), .first_fail_mask(ffm[1])
  );
  demorgan_sweep_checker #(.SETTLE_CYCLES(0), .REPEAT(1), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .drv_a(drvA[2]), .drv_b(drvB[2]),
    .obs(obs[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .fail_count(fc[2]),
    .first_fail_vec(ffv[2]), .first_fail_mask(ffm[2])
  );
  demorgan_sweep_checker #(.SETTLE_CYCLES(1), .REPEAT(1), .CNT_W(2)) dut3 (
    .clk(clk), .reset(reset), .start(start[3]), .drv_a(drvA[3]), .drv_b(drvB[3]),
    .obs(obs[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]), .fail_count(fc3),
    .first_fail_vec(ffv[3]), .first_fail_mask(ffm[3])
  );

  demorgan_golden uGold (
    .vec      (gVec),
    .expected (gExp)
  );

  typedef struct {
    logic [1:0] vec;
    logic [7:0] exp;
  } goldVecT;

  typedef struct {
    int         dut;
    logic [7:0] clr;
    logic [7:0] xr;
    int         expBusy;
    int         expFc;
    logic [1:0] expFv;
    logic [7:0] expFm;
  } runVecT;

  goldVecT goldTbl [4];
  runVecT  runTbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int settleOf(input int i);
    return (i == 2) ? 0 : 1;
  endfunction

  function automatic logic [31:0] outBundle(input int i);
    return 32'({drvA[i], drvB[i], busy[i], done[i], pass[i], fc[i], ffv[i], ffm[i]});
  endfunction

  // Scoreboard: expected results of a run from the fault masks
  task automatic modelRun(input int repeatN, input int cntMax, input logic [7:0] clr,
                          input logic [7:0] xr, output int cnt, output logic [1:0] fv,
                          output logic [7:0] fm);
    logic [7:0] e;
    logic [7:0] o;
    cnt = 0;
    fv  = '0;
    fm  = '0;
    for (int s = 0; s < repeatN; s++) begin
      for (int v = 0; v < 4; v++) begin
        e = gateModel(2'(v));
        o = (e & ~clr) ^ xr;
        if (o != e) begin
          if (cnt == 0) begin
            fv = 2'(v);
            fm = o ^ e;
          end
          if (cnt < cntMax) cnt++;
        end
      end
    end
  endtask

  // Called on a negedge; pulses start and follows the run to its done pulse
  task automatic runRun(input int i, input int settle, input int limit, output int busyN,
                        output int doneAt, output logic passAtDone);
    int cyc;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    cyc   = 1;
    busyN = 0;
    while (!done[i] && cyc < limit) begin
      if (busy[i]) begin
        check($sformatf("drv%0d_c%0d", i, cyc), 32'({drvA[i], drvB[i]}),
              32'(((cyc - 1) / (settle + 1)) % 4));
        busyN++;
      end
      @(negedge clk);
      cyc++;
    end
    doneAt     = done[i] ? cyc : -1;
    passAtDone = pass[i];
    check($sformatf("busy_low_at_done%0d", i), 32'(busy[i]), 32'(0));
    @(negedge clk);
    check($sformatf("done_pulse%0d", i), 32'({done[i], drvA[i], drvB[i]}), 32'(0));
  endtask

  task automatic doRun(input string tag, input int i, input int expBusy, input int expFc,
                       input logic [1:0] expFv, input logic [7:0] expFm);
    int   busyN;
    int   doneAt;
    logic pd;
    runRun(i, settleOf(i), 200, busyN, doneAt, pd);
    check({tag, "_busy_cycles"}, 32'(busyN), 32'(expBusy));
    check({tag, "_done_at"}, 32'(doneAt), 32'(expBusy + 1));
    check({tag, "_pass_at_done"}, 32'(pd), 32'(expFc == 0));
    repeat (2) @(negedge clk);
    check({tag, "_fail_count"}, 32'(fc[i]), 32'(expFc));
    check({tag, "_first_vec"}, 32'(ffv[i]), 32'(expFv));
    check({tag, "_first_mask"}, 32'(ffm[i]), 32'(expFm));
    check({tag, "_pass_held"}, 32'(pass[i]), 32'(expFc == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         ph;
    int         ri;
    int         rep;
    int         cnt;
    logic [1:0] fv;
    logic [7:0] fm;

    for (int i = 0; i < 4; i++) begin
      start[i]   = 1'b0;
      clrMask[i] = '0;
      xorMask[i] = '0;
    end
    gVec = '0;

    goldTbl[0] = '{vec: 2'b00, exp: 8'hB7};
    goldTbl[1] = '{vec: 2'b01, exp: 8'h71};
    goldTbl[2] = '{vec: 2'b10, exp: 8'h72};
    goldTbl[3] = '{vec: 2'b11, exp: 8'h48};

    runTbl[0] = '{dut: 0, clr: 8'h00, xr: 8'h00, expBusy: 8,  expFc: 0,  expFv: 2'b00, expFm: 8'h00};
    runTbl[1] = '{dut: 0, clr: 8'h08, xr: 8'h00, expBusy: 8,  expFc: 1,  expFv: 2'b11, expFm: 8'h08};
    runTbl[2] = '{dut: 1, clr: 8'h00, xr: 8'h40, expBusy: 24, expFc: 12, expFv: 2'b00, expFm: 8'h40};
    runTbl[3] = '{dut: 3, clr: 8'h00, xr: 8'hFF, expBusy: 8,  expFc: 3,  expFv: 2'b00, expFm: 8'hFF};

    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("reset_outputs%0d", i), outBundle(i), 32'(0));

    for (int k = 0; k < 4; k++) begin
      gVec = goldTbl[k].vec;
      #1;
      check($sformatf("golden_%0d", k), 32'(gExp), 32'(goldTbl[k].exp));
    end

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      clrMask[runTbl[k].dut] = runTbl[k].clr;
      xorMask[runTbl[k].dut] = runTbl[k].xr;
      doRun($sformatf("run%0d", k), runTbl[k].dut, runTbl[k].expBusy, runTbl[k].expFc,
            runTbl[k].expFv, runTbl[k].expFm);
      clrMask[runTbl[k].dut] = '0;
      xorMask[runTbl[k].dut] = '0;
    end

    // Reset between edges in the middle of vec=2's settle cycle
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_drv", 32'({busy[0], drvA[0], drvB[0]}), 32'(3'b110));
    #1 reset = 1'b1;
    #1;
    check("async_reset_outputs", outBundle(0), 32'(0));
    @(negedge clk);
    check("reset_held_outputs", outBundle(0), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    doRun("post_reset", 0, 8, 0, 2'b00, 8'h00);

    // start held high on the zero-settle instance: back-to-back 6-cycle runs
    start[2] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      ph = (k - 1) % 6;
      check($sformatf("held_c%0d", k), 32'({busy[2], done[2]}),
            32'({ph < 4, ph == 4}));
      if (ph < 4) check($sformatf("held_drv_c%0d", k), 32'({drvA[2], drvB[2]}), 32'(ph));
    end
    start[2] = 1'b0;
    repeat (2) @(negedge clk);
    check("held_idle_after", 32'({busy[2], done[2], pass[2]}), 32'(3'b001));

    for (int r = 0; r < 16; r++) begin
      ri  = ($urandom_range(0, 1) == 1) ? 1 : 0;
      rep = (ri == 1) ? 3 : 1;
      if ($urandom_range(0, 3) == 0) begin
        clrMask[ri] = '0;
        xorMask[ri] = '0;
      end else begin
        clrMask[ri] = 8'($urandom & $urandom);
        xorMask[ri] = 8'($urandom & $urandom & $urandom);
      end
      modelRun(rep, 255, clrMask[ri], xorMask[ri], cnt, fv, fm);
      doRun($sformatf("rnd%0d", r), ri, 8 * rep, cnt, fv, fm);
      clrMask[ri] = '0;
      xorMask[ri] = '0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
